// File: rtl/gate_bist.sv
// Built-in self test for the primitive gate library: sweeps {a,b} through all
// four patterns, samples the five gate outputs and accumulates mismatch results.
module gate_bist #(
    parameter int SETTLE = 2,
    parameter int ROUNDS = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       a,
    output logic       b,
    input  logic       nand_in,
    input  logic       not_in,
    input  logic       or_in,
    input  logic       exor_in,
    input  logic       and_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_mask,
    output logic [7:0] err_count,
    output logic       first_fail_valid,
    output logic [1:0] first_fail_ab
);

    localparam int WW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam logic [WW-1:0] WLAST = WW'(SETTLE - 1);
    localparam logic [RW-1:0] RLAST = RW'(ROUNDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CHECK, S_DONE} state_t;

    state_t          r_state, w_state;
    logic [1:0]      r_p, w_p;
    logic [RW-1:0]   r_round, w_round;
    logic [WW-1:0]   r_wait, w_wait;
    logic            r_a, r_b, r_busy, r_done, r_pass, r_ffv;
    logic            w_a, w_b, w_busy, w_done, w_pass, w_ffv;
    logic [4:0]      r_mask, w_mask;
    logic [7:0]      r_cnt, w_cnt;
    logic [1:0]      r_ffab, w_ffab;

    logic [4:0]      w_gold, w_mis;
    logic [2:0]      w_pop;
    logic [8:0]      w_sum;
    logic [7:0]      w_cnt_sat;

    // Bit order matches err_mask: [0] nand, [1] not, [2] or, [3] exor, [4] and
    assign w_gold = {r_a & r_b, r_a ^ r_b, r_a | r_b, ~r_a, ~(r_a & r_b)};
    assign w_mis  = w_gold ^ {and_in, exor_in, or_in, not_in, nand_in};
    assign w_pop  = 3'(w_mis[0]) + 3'(w_mis[1]) + 3'(w_mis[2]) + 3'(w_mis[3]) + 3'(w_mis[4]);
    assign w_sum  = 9'(r_cnt) + 9'(w_pop);
    assign w_cnt_sat = w_sum[8] ? 8'hFF : w_sum[7:0];

    always_comb begin
        w_state = r_state;
        w_p     = r_p;
        w_round = r_round;
        w_wait  = r_wait;
        w_mask  = r_mask;
        w_cnt   = r_cnt;
        w_ffv   = r_ffv;
        w_ffab  = r_ffab;
        w_pass  = r_pass;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state = S_WAIT;
                    w_p     = '0;
                    w_round = '0;
                    w_wait  = '0;
                    w_mask  = '0;
                    w_cnt   = '0;
                    w_ffv   = 1'b0;
                    w_ffab  = '0;
                    w_pass  = 1'b0;
                end
            end
            S_WAIT: begin
                if (r_wait == WLAST) w_state = S_CHECK;
                else                 w_wait  = r_wait + WW'(1);
            end
            S_CHECK: begin
                w_mask = r_mask | w_mis;
                w_cnt  = w_cnt_sat;
                if (w_mis != '0 && !r_ffv) begin
                    w_ffv  = 1'b1;
                    w_ffab = {r_a, r_b};
                end
                w_wait = '0;
                if (r_p != 2'd3) begin
                    w_p     = r_p + 2'd1;
                    w_state = S_WAIT;
                end else if (r_round != RLAST) begin
                    w_p     = '0;
                    w_round = r_round + RW'(1);
                    w_state = S_WAIT;
                end else begin
                    w_state = S_DONE;
                end
            end
            S_DONE:  w_state = S_IDLE;
            default: w_state = S_IDLE;
        endcase
        // Outputs are registered, so they are derived from the next state.
        if (w_state == S_DONE) w_pass = (w_cnt == '0);
        w_busy = (w_state == S_WAIT) || (w_state == S_CHECK);
        w_done = (w_state == S_DONE);
        w_a    = w_busy & w_p[0];
        w_b    = w_busy & w_p[1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_p     <= '0;
            r_round <= '0;
            r_wait  <= '0;
            r_a     <= 1'b0;
            r_b     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_ffv   <= 1'b0;
            r_mask  <= '0;
            r_cnt   <= '0;
            r_ffab  <= '0;
        end else begin
            r_state <= w_state;
            r_p     <= w_p;
            r_round <= w_round;
            r_wait  <= w_wait;
            r_a     <= w_a;
            r_b     <= w_b;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_pass  <= w_pass;
            r_ffv   <= w_ffv;
            r_mask  <= w_mask;
            r_cnt   <= w_cnt;
            r_ffab  <= w_ffab;
        end
    end

    assign a                = r_a;
    assign b                = r_b;
    assign busy             = r_busy;
    assign done             = r_done;
    assign pass             = r_pass;
    assign err_mask         = r_mask;
    assign err_count        = r_cnt;
    assign first_fail_valid = r_ffv;
    assign first_fail_ab    = r_ffab;

endmodule

// File: doc/gate_bist.md
# gate_bist

Self-checking built-in test controller for the primitive gate library (NAND2, NOT1, OR2, EXOR2, AND2). It is the response end of the gate stimulus loop. It drives the shared `a`/`b` inputs through all four input combinations, waits a programmable settle time, and samples the five gate outputs. It compares each sample against golden truth tables and reports pass/fail, a sticky per-gate error mask, and a saturating mismatch count. It replaces manual waveform inspection of the gate bench, and is reused as the power-on check in front of the ALU datapath.

## Interface

Parameters:
- `SETTLE`, default 2: wait cycles after each new pattern before sampling. Legal range is 1 or more.
- `ROUNDS`, default 1: number of complete 4-pattern passes per run. Legal range is 1 or more.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  run request; sampled only in IDLE
- `a`, `b`  out  1 each  registered stimulus to the gates under test
- `nand_in`, `not_in`, `or_in`, `exor_in`, `and_in`  in  1 each  outputs of the gates under test (combinational from `a`/`b`)
- `busy`  out  1  run in progress
- `done`  out  1  one-cycle pulse at end of run
- `pass`  out  1  1 when the last run had zero mismatches; held until next start
- `err_mask`  out  5  sticky per-gate fail bits: [0] nand, [1] not, [2] or, [3] exor, [4] and
- `err_count`  out  8  total mismatching bits in the run, saturating at 255
- `first_fail_valid`  out  1  at least one mismatch seen
- `first_fail_ab`  out  2  {a,b} of the first failing pattern

## Operation

- Golden values:
  - nand = ~(a&b)
  - not = ~a
  - or = a|b
  - exor = a^b
  - and = a&b
- Pattern index `p` runs 0..3, with `a` = p[0] and `b` = p[1]. This gives the order (a,b) = 00, 10, 01, 11, repeated for ROUNDS passes.
- FSM states: IDLE, WAIT, CHECK, DONE.
  - **IDLE:** `a` = `b` = 0 and `busy` = 0. If `start` = 1, clear `err_mask`, `err_count`, `pass`, `first_fail_*`; set p = 0 and round = 0; go to WAIT.
  - **WAIT:** `a`/`b` hold pattern p. Stay for SETTLE cycles, then go to CHECK.
  - **CHECK:** one cycle. At its closing edge:
    - compute a 5-bit mismatch vector;
    - OR it into `err_mask`;
    - add its popcount (0..5) to `err_count`, saturating at 255;
    - if the vector is non-zero and `first_fail_valid` = 0, capture {a,b} into `first_fail_ab` and set `first_fail_valid`.
  - **Leaving CHECK:**
    - if p < 3: p++, go to WAIT.
    - else if round < ROUNDS-1: p = 0, round++, go to WAIT.
    - else go to DONE.
  - **DONE:** one cycle. `done` = 1, `busy` = 0, and `a` = `b` = 0. `pass` is set to (`err_count` == 0 including the final CHECK). Next state is IDLE.
- `start` is ignored outside IDLE. No abort input; only reset stops a run.
- Result outputs (`pass`, `err_mask`, `err_count`, `first_fail_*`) hold from DONE until the next accepted start.

## Timing

- All outputs are registered.
- Reset (`rst_n` = 0), asynchronous and valid at any state, including mid-run:
  - state goes to IDLE immediately;
  - `a`, `b`, `busy`, `done`, `pass`, `first_fail_valid` = 0;
  - `err_mask`, `err_count`, `first_fail_ab` = 0.
- Start accepted at edge E0. Pattern 0 appears on `a`/`b` and `busy` rises in the cycle after E0.
- Each pattern occupies SETTLE+1 cycles (SETTLE WAIT cycles plus one CHECK cycle).
- `done` is high in the cycle after edge E0 + 4·ROUNDS·(SETTLE+1). With the defaults that is 12 cycles after E0, so `done` is visible in cycle 13.
- `start` held high continuously gives back-to-back runs separated by exactly one IDLE cycle. Each new run clears the results.
- Gate outputs are sampled only at the closing edge of CHECK. Glitches during WAIT are ignored.

## Test plan

1. **All gates correct** (defaults), 1-cycle start pulse:
   - `a`/`b` sequence 00,10,01,11, 3 cycles each;
   - `done` pulse 13 cycles after start;
   - `pass` = 1, `err_mask` = 0, `err_count` = 0, `first_fail_valid` = 0.
2. **AND2 wired to `nand_in`** (the current bench miswiring):
   - `err_mask` = 5'b00001, `err_count` = 4, `first_fail_ab` = 2'b00, `pass` = 0.
3. **`or_in` stuck at 0:**
   - mismatches at patterns 10, 01, 11;
   - `err_count` = 3, `err_mask` = 5'b00100, `first_fail_ab` = 2'b10.
4. **All five inputs inverted, ROUNDS = 100:**
   - raw mismatch total 2000;
   - `err_count` saturates at 255, `err_mask` = 5'b11111;
   - no wrap observed at any point.
5. **`start` held high for 40 cycles** (defaults):
   - a second run begins after one IDLE cycle;
   - results of run 1 are visible for exactly that DONE/IDLE window and then cleared;
   - `start` during `busy` has no effect.
6. **`rst_n` pulsed low during WAIT of pattern 01**, with `or_in` stuck at 0:
   - all outputs 0 immediately, asynchronous to `clk`;
   - a subsequent start with correct gates yields `pass` = 1 and `err_count` = 0.
